deserializer_fifo: RTL and testbench

Parametrised serial-to-parallel receiver that assembles `WIDTH`-bit words from a qualified bit stream and buffers completed words in a `DEPTH`-entry output queue. It sits between the serial link and the queue consumer, and lets the link keep receiving while earlier words wait for acknowledgement. It also adds bit-order selection, overrun reporting and a synchronous flush.

---
 rtl/deserializer_fifo_pkg.sv | 16 +
 rtl/deserializer_fifo_if.sv | 29 ++
 rtl/deserializer_fifo_word_fifo.sv | 61 ++++++
 rtl/deserializer_fifo.sv | 115 +++++++++++
 tb/tb_deserializer_fifo.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/deserializer_fifo_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
package deserializer_pkg;

  // Receiver states: IDLE has no bits held, SHIFT holds a partial word,
  // FULL means the output queue cannot take another word.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } des_state_t;

  // Bit-order selectors for the MSB_FIRST parameter.
  localparam bit LSB_FIRST_C = 1'b0;
  localparam bit MSB_FIRST_C = 1'b1;

endpackage

// File: rtl/deserializer_fifo_if.sv
// Serial link / word queue bundle between the receiver and its neighbours.
interface deserializer_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);

  logic                       data_in;
  logic                       write_in;
  logic                       clear;
  logic                       ack_in;
  logic                       status_out;
  logic                       data_ready;
  logic [WIDTH-1:0]           data_out;
  logic [$clog2(DEPTH+1)-1:0] word_count;
  logic                       overrun;

  // Link and consumer side: drives bits, acks and flush.
  modport master (
    output data_in, write_in, clear, ack_in,
    input  status_out, data_ready, data_out, word_count, overrun
  );

  // Receiver side.
  modport slave (
    input  data_in, write_in, clear, ack_in,
    output status_out, data_ready, data_out, word_count, overrun
  );

endinterface

// File: rtl/deserializer_fifo_word_fifo.sv
// Small circular word queue with synchronous flush; head reads as 0 when empty.
module word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (DEPTH == 1) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (DEPTH == 1) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/deserializer_fifo.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words and queues them.
module deserializer_fifo
  import deserializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic               clock_100KHz,
  input  logic               reset,
  deserializer_fifo_if.slave bus
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  des_state_t       state;
  des_state_t       next_state;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             overrun_q;
  logic             status;
  logic             accept;
  logic             last_bit;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  assign status   = (state != FULL);
  assign accept   = bus.write_in && status && !bus.clear;
  assign last_bit = accept && (bit_cnt == BIT_W'(WIDTH-1));
  assign pop      = bus.ack_in && !empty && !bus.clear;

  if (MSB_FIRST == int'(MSB_FIRST_C)) begin : g_msb_first
    assign shift_next = {shift_reg[WIDTH-2:0], bus.data_in};
  end else begin : g_lsb_first
    assign shift_next = {bus.data_in, shift_reg[WIDTH-1:1]};
  end

  // Receiver state register.
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: FULL is entered only when a push fills the queue with no pop alongside.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
          next_state = ((count == CNT_W'(DEPTH-1)) && !pop) ? FULL : IDLE;
        end
      end
      FULL: begin
        if (pop || !full) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (bus.clear) next_state = IDLE;
  end

  // Shift register, bit counter and sticky overrun flag.
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      overrun_q <= 1'b0;
    end else if (bus.clear) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        shift_reg <= shift_next;
        bit_cnt   <= last_bit ? '0 : bit_cnt + BIT_W'(1);
      end
      if (bus.write_in && !status) begin
        overrun_q <= 1'b1;
      end
    end
  end

  word_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_word_fifo (
    .clk   (clock_100KHz),
    .rst_n (reset),
    .push  (last_bit),
    .pop   (pop),
    .clear (bus.clear),
    .wdata (shift_next),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.status_out = status;
  assign bus.data_ready = !empty;
  assign bus.data_out   = head;
  assign bus.word_count = count;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_deserializer_fifo.sv
// Directed bench: one LSB-first and one MSB-first receiver fed the same stream.
module tb_deserializer_fifo;

  logic clock_100KHz;
  logic reset;
  int   checks;
  int   errors;

  deserializer_fifo_if #(.WIDTH(8), .DEPTH(2)) lsbBus ();
  deserializer_fifo_if #(.WIDTH(8), .DEPTH(2)) msbBus ();

  deserializer_fifo #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(0)) dutLsb (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .bus          (lsbBus)
  );

  deserializer_fifo #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1)) dutMsb (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .bus          (msbBus)
  );

  // Free-running clock.
  initial begin
    clock_100KHz = 1'b0;
    forever #5 clock_100KHz = ~clock_100KHz;
  end

  // Drive both receivers for one cycle, then settle just past the edge.
  task automatic applyStimulus(input logic wr, input logic bitVal, input logic ack, input logic clr);
    lsbBus.write_in = wr;
    lsbBus.data_in  = bitVal;
    lsbBus.ack_in   = ack;
    lsbBus.clear    = clr;
    msbBus.write_in = wr;
    msbBus.data_in  = bitVal;
    msbBus.ack_in   = ack;
    msbBus.clear    = clr;
    @(posedge clock_100KHz);
    #1;
  endtask

  // Send the given number of bits of a value, bit 0 first.
  task automatic sendBits(input logic [7:0] value, input int nBits);
    for (int i = 0; i < nBits; i++) begin
      applyStimulus(1'b1, value[i], 1'b0, 1'b0);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_status", 32'(lsbBus.status_out), 32'd1);
    checkOutput("rst_ready", 32'(lsbBus.data_ready), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_status", 32'(lsbBus.status_out), 32'd1);
    checkOutput("idle_ready", 32'(lsbBus.data_ready), 32'd0);
    checkOutput("idle_data", 32'(lsbBus.data_out), 32'h0);
    checkOutput("idle_count", 32'(lsbBus.word_count), 32'd0);
    checkOutput("idle_overrun", 32'(lsbBus.overrun), 32'd0);
    checkOutput("idle_msb_status", 32'(msbBus.status_out), 32'd1);

    // Stream 1,0,1,0,0,1,0,1 -> 0xA5 in both bit orders.
    sendBits(8'hA5, 7);
    checkOutput("a5_partial_ready", 32'(lsbBus.data_ready), 32'd0);
    sendBits(8'h01, 1);
    checkOutput("a5_ready", 32'(lsbBus.data_ready), 32'd1);
    checkOutput("a5_lsb_data", 32'(lsbBus.data_out), 32'hA5);
    checkOutput("a5_msb_data", 32'(msbBus.data_out), 32'hA5);
    checkOutput("a5_count", 32'(lsbBus.word_count), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("a5_pop_ready", 32'(lsbBus.data_ready), 32'd0);
    checkOutput("a5_pop_data", 32'(lsbBus.data_out), 32'h0);
    checkOutput("a5_pop_count", 32'(lsbBus.word_count), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("empty_ack_count", 32'(lsbBus.word_count), 32'd0);

    // Stream 0,0,0,0,0,0,0,1: LSB-first 0x80, MSB-first 0x01.
    sendBits(8'h80, 8);
    checkOutput("x01_lsb_data", 32'(lsbBus.data_out), 32'h80);
    checkOutput("x01_msb_data", 32'(msbBus.data_out), 32'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Fill the two-entry queue, then overrun it.
    sendBits(8'h11, 8);
    checkOutput("fill1_count", 32'(lsbBus.word_count), 32'd1);
    checkOutput("fill1_status", 32'(lsbBus.status_out), 32'd1);
    sendBits(8'h22, 8);
    checkOutput("fill2_count", 32'(lsbBus.word_count), 32'd2);
    checkOutput("fill2_status", 32'(lsbBus.status_out), 32'd0);
    checkOutput("fill2_head", 32'(lsbBus.data_out), 32'h11);
    checkOutput("fill2_msb_head", 32'(msbBus.data_out), 32'h88);
    checkOutput("fill2_overrun", 32'(lsbBus.overrun), 32'd0);
    sendBits(8'h07, 3);
    checkOutput("ovr_flag", 32'(lsbBus.overrun), 32'd1);
    checkOutput("ovr_count", 32'(lsbBus.word_count), 32'd2);
    checkOutput("ovr_head", 32'(lsbBus.data_out), 32'h11);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("full_pop_head", 32'(lsbBus.data_out), 32'h22);
    checkOutput("full_pop_msb_head", 32'(msbBus.data_out), 32'h44);
    checkOutput("full_pop_status", 32'(lsbBus.status_out), 32'd1);
    checkOutput("full_pop_count", 32'(lsbBus.word_count), 32'd1);
    checkOutput("ovr_sticky", 32'(lsbBus.overrun), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("drain_ready", 32'(lsbBus.data_ready), 32'd0);

    // Push and pop on the same edge leave the count unchanged.
    sendBits(8'h33, 8);
    checkOutput("q33_head", 32'(lsbBus.data_out), 32'h33);
    checkOutput("q33_msb_head", 32'(msbBus.data_out), 32'hCC);
    sendBits(8'h44, 7);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("pushpop_count", 32'(lsbBus.word_count), 32'd1);
    checkOutput("pushpop_head", 32'(lsbBus.data_out), 32'h44);
    checkOutput("pushpop_msb_head", 32'(msbBus.data_out), 32'h22);
    checkOutput("pushpop_status", 32'(lsbBus.status_out), 32'd1);

    // Flush with a queued word, a partial word and a simultaneous bit and ack.
    sendBits(8'h1F, 5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("clr_overrun", 32'(lsbBus.overrun), 32'd0);
    checkOutput("clr_count", 32'(lsbBus.word_count), 32'd0);
    checkOutput("clr_ready", 32'(lsbBus.data_ready), 32'd0);
    checkOutput("clr_status", 32'(lsbBus.status_out), 32'd1);
    sendBits(8'hC3, 8);
    checkOutput("clr_c3_data", 32'(lsbBus.data_out), 32'hC3);
    checkOutput("clr_c3_msb_data", 32'(msbBus.data_out), 32'hC3);
    checkOutput("clr_c3_count", 32'(lsbBus.word_count), 32'd1);

    // Asynchronous reset with a queued word and a partial word in flight.
    sendBits(8'h1F, 5);
    reset = 1'b0;
    #2;
    checkOutput("arst_ready", 32'(lsbBus.data_ready), 32'd0);
    checkOutput("arst_count", 32'(lsbBus.word_count), 32'd0);
    checkOutput("arst_data", 32'(lsbBus.data_out), 32'h0);
    reset = 1'b1;
    sendBits(8'hC3, 8);
    checkOutput("arst_c3_data", 32'(lsbBus.data_out), 32'hC3);
    checkOutput("arst_c3_count", 32'(lsbBus.word_count), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
